// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Registered fields have one cycle of latency; forwarding and ALU operand muxing are combinational.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_op,
  input  logic        id_src_a,
  input  logic        id_src_b,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_operation,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] store_data,
  output logic        load_use_hazard
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [3:0]  r_alu_op;
  logic        r_src_a;
  logic        r_src_b;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  logic        w_load_use;
  logic        w_bubble;
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;

  // A load in EX whose destination is read by the instruction in ID must delay it one cycle.
  always_comb begin
    w_load_use = id_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                 ((r_rd == id_rs1) || (r_rd == id_rs2));
  end

  always_comb begin
    w_bubble = flush || (!stall && (w_load_use || !id_valid));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_alu_op    <= ALU_ADD;
      r_src_a     <= 1'b0;
      r_src_b     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_pc        <= id_pc;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_alu_op    <= id_alu_op;
      r_src_a     <= id_src_a;
      r_src_b     <= id_src_b;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end
  end

  // EX/MEM is checked first so the youngest in-flight value wins; x0 is never forwarded.
  always_comb begin
    w_fwd1 = r_rs1_data;
    if (FWD_EN && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs1)) begin
      w_fwd1 = mem_result;
    end else if (FWD_EN && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs1)) begin
      w_fwd1 = wb_result;
    end
  end

  always_comb begin
    w_fwd2 = r_rs2_data;
    if (FWD_EN && mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs2)) begin
      w_fwd2 = mem_result;
    end else if (FWD_EN && wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs2)) begin
      w_fwd2 = wb_result;
    end
  end

  always_comb begin
    alu_a           = r_src_a ? r_pc : w_fwd1;
    alu_b           = r_src_b ? r_imm : w_fwd2;
    store_data      = w_fwd2;
    alu_operation   = r_alu_op;
    ex_valid        = r_valid;
    ex_pc           = r_pc;
    ex_rd           = r_rd;
    ex_reg_write    = r_reg_write;
    ex_mem_read     = r_mem_read;
    ex_mem_write    = r_mem_write;
    load_use_hazard = w_load_use;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a transaction-level model of the EX slot is compared
// against two DUTs (forwarding on and off) every cycle, plus hand-computed directed checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;

  logic [31:0] alu_a, alu_b, ex_pc, store_data;
  logic [3:0]  alu_operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_rd;

  logic [31:0] n_alu_a, n_alu_b, n_ex_pc, n_store_data;
  logic [3:0]  n_alu_operation;
  logic        n_ex_valid, n_ex_reg_write, n_ex_mem_read, n_ex_mem_write, n_load_use_hazard;
  logic [4:0]  n_ex_rd;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .store_data(store_data), .load_use_hazard(load_use_hazard)
  );

  id_ex_stage #(.FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_operation(n_alu_operation),
    .ex_valid(n_ex_valid), .ex_pc(n_ex_pc), .ex_rd(n_ex_rd), .ex_reg_write(n_ex_reg_write),
    .ex_mem_read(n_ex_mem_read), .ex_mem_write(n_ex_mem_write), .store_data(n_store_data),
    .load_use_hazard(n_load_use_hazard)
  );

  // Model: the instruction occupying EX, or an all-zero bubble.
  typedef struct packed {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        sa, sb, rw, mr, mw;
  } ex_t;

  ex_t m;

  function automatic logic model_haz(input ex_t c);
    return id_valid && c.v && c.mr && (c.rd != 5'd0) && ((c.rd == id_rs1) || (c.rd == id_rs2));
  endfunction

  function automatic ex_t model_next(input ex_t c);
    ex_t n;
    n = '0;
    if (flush) n = '0;
    else if (stall) n = c;
    else if (model_haz(c) || !id_valid) n = '0;
    else begin
      n.v = 1'b1; n.pc = id_pc; n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.op = id_alu_op;
      n.sa = id_src_a; n.sb = id_src_b; n.rw = id_reg_write; n.mr = id_mem_read;
      n.mw = id_mem_write;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic [31:0] d,
                                                input bit en);
    if (en && rs != 0 && mem_reg_write && mem_rd == rs) return mem_result;
    if (en && rs != 0 && wb_reg_write && wb_rd == rs) return wb_result;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      chk("ex_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, m.rw, m.mr, m.mw});
      chk("alu_operation", {28'd0, alu_operation}, {28'd0, m.op});
      chk("alu_a", alu_a, m.sa ? m.pc : model_operand(m.rs1, m.d1, 1'b1));
      chk("alu_b", alu_b, m.sb ? m.imm : model_operand(m.rs2, m.d2, 1'b1));
      chk("store_data", store_data, model_operand(m.rs2, m.d2, 1'b1));
      chk("load_use_hazard", {31'd0, load_use_hazard}, {31'd0, model_haz(m)});
      chk("nofwd_alu_a", n_alu_a, m.sa ? m.pc : m.d1);
      chk("nofwd_store_data", n_store_data, m.d2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] op,
                        input logic sa, input logic sb, input logic rw, input logic mr,
                        input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_alu_op = op; id_src_a = sa; id_src_b = sb;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    mem_rd = mrd; mem_reg_write = mrw; mem_result = mres;
    wb_rd = wrd; wb_reg_write = wrw; wb_result = wres;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    step(); step();
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_hazard", {31'd0, load_use_hazard}, 32'd0);
    rst_n = 1'b1;

    // Basic capture: rs1=5, rs2=7, imm=0x10 via src_b.
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h10, 4'd3, 0, 1, 1, 0, 0);
    step();
    id_valid = 1'b0;
    chk("cap_alu_a", alu_a, 32'd5);
    chk("cap_alu_b", alu_b, 32'h10);
    chk("cap_store_data", store_data, 32'd7);
    chk("cap_alu_op", {28'd0, alu_operation}, 32'd3);

    // Forwarding priority on rs1=3, held in EX by stall.
    set_id(1'b1, 32'h200, 5'd3, 5'd6, 5'd8, 32'h11, 32'h22, 32'h0, 4'd2, 0, 0, 1, 0, 0);
    step();
    id_valid = 1'b0; stall = 1'b1;
    set_fwd(5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB);
    #1 chk("fwd_mem_wins", alu_a, 32'hAA);
    chk("nofwd_registered", n_alu_a, 32'h11);
    mem_reg_write = 1'b0;
    #1 chk("fwd_wb", alu_a, 32'hBB);
    set_fwd(5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB);
    #1 chk("fwd_x0_blocked", alu_a, 32'h11);
    set_fwd(5'd6, 1'b1, 32'hCC, 5'd0, 1'b0, 32'h0);
    #1 chk("fwd_store_data", store_data, 32'hCC);
    set_fwd(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    chk("stall_hold_pc", ex_pc, 32'h200);
    chk("stall_hold_alu_a", alu_a, 32'h11);
    flush = 1'b1;
    step();
    chk("flush_over_stall", {31'd0, ex_valid}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Load-use: load to x4 in EX, consumer reads x4 as rs2.
    set_id(1'b1, 32'h300, 5'd0, 5'd0, 5'd4, 0, 0, 0, 4'd0, 0, 1, 1, 1, 0);
    step();
    set_id(1'b1, 32'h304, 5'd1, 5'd4, 5'd7, 32'h1, 32'h2, 0, 4'd1, 0, 0, 1, 0, 0);
    #1 chk("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_cleared", {31'd0, load_use_hazard}, 32'd0);
    step();
    chk("lu_retry_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_retry_pc", ex_pc, 32'h304);
    chk("lu_retry_rd", {27'd0, ex_rd}, 32'd7);

    // A load to x0 never creates a hazard.
    set_id(1'b1, 32'h400, 5'd0, 5'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
    step();
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1 chk("lu_x0", {31'd0, load_use_hazard}, 32'd0);

    // Mixed traffic over a small register range so forwarding and hazards collide.
    for (int i = 0; i < 40; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      set_fwd(5'($urandom_range(0, 3)), 1'($urandom), $urandom,
              5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step();
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-cycle with a valid instruction in EX.
    set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd9, 0, 0, 0, 4'd5, 0, 0, 1, 0, 0);
    step();
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("async_rst_op", {28'd0, alu_operation}, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter FWD_EN, default 1, meaning: 1 enables EX/MEM and MEM/WB operand forwarding; 0 passes register-file operands unchanged.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid, id_pc[31:0], id_rs1_data[31:0], id_rs2_data[31:0], id_imm[31:0]  input  decode-stage instruction and operands.
REQ-005 id_rs1[4:0], id_rs2[4:0], id_rd[4:0], id_alu_op[3:0], id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write  input  decode-stage fields and controls.
REQ-006 stall  input  1  hold stage contents; flush  input  1  replace stage contents with bubble.
REQ-007 mem_rd[4:0], mem_reg_write, mem_result[31:0]  input  EX/MEM forwarding source; wb_rd[4:0], wb_reg_write, wb_result[31:0]  input  MEM/WB forwarding source.
REQ-008 alu_a[31:0], alu_b[31:0], alu_operation[3:0]  output  ALU operands and opcode.
REQ-009 ex_valid, ex_pc[31:0], ex_rd[4:0], ex_reg_write, ex_mem_read, ex_mem_write, store_data[31:0]  output  registered instruction state for downstream.
REQ-010 load_use_hazard  output  1  combinational request to stall fetch/decode.

Function
REQ-011 Stage register captures all id_* inputs on each rising edge when stall=0, flush=0, load_use_hazard=0.
REQ-012 Bubble = ex_valid 0, ex_reg_write 0, ex_mem_read 0, ex_mem_write 0, alu_operation ALU_ADD, ex_rd 0, all data fields 0.
REQ-013 Priority per edge: flush > stall > load_use_hazard > normal capture.
REQ-014 flush=1: bubble loaded next edge regardless of stall.
REQ-015 stall=1 (flush=0): all registered state held unchanged.
REQ-016 load_use_hazard=1 (stall=0, flush=0): bubble loaded; decode inputs not consumed.
REQ-017 load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-018 id_valid=0 captured as bubble (controls forced 0).
REQ-019 Forwarded rs1 (fwd1): if FWD_EN & mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1 -> mem_result; else if FWD_EN & wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1 -> wb_result; else registered rs1_data; fwd2 identical for rs2.
REQ-020 EX/MEM source wins when both sources match same register.
REQ-021 Register x0 never forwarded; x0 operand always registered value.
REQ-022 alu_a = ex_src_a ? ex_pc : fwd1; alu_b = ex_src_b ? ex_imm : fwd2; store_data = fwd2.
REQ-023 Forwarding and operand muxing purely combinational; zero added latency; registered fields one-cycle latency ID->EX.
REQ-024 All data paths 32-bit, no width extension or truncation.

Reset
REQ-025 rst_n=0 asynchronously loads bubble (REQ-012) immediately, independent of clk.
REQ-026 During reset load_use_hazard=0; first capture on first rising edge after rst_n=1.
REQ-027 Reset mid-stall or mid-hazard discards held instruction; no state survives.

Verification
REQ-028 rst_n low mid-cycle with ex_valid=1 -> ex_valid=0, ex_reg_write=0, alu_operation=ALU_ADD before next edge.
REQ-029 Capture rs1_data=5, rs2_data=7, imm=0x10, src_b=1; no matching forwards -> alu_a=5, alu_b=0x10, store_data=7 after one edge.
REQ-030 ex_rs1=3; mem_rd=3 result 0xAA, wb_rd=3 result 0xBB, both reg_write=1 -> alu_a=0xAA; clear mem_reg_write -> alu_a=0xBB; set rd=0 on both -> registered value.
REQ-031 ex: mem_read=1, rd=4; id: valid=1, rs2=4 -> load_use_hazard=1, next edge ex_valid=0, id instruction captured following edge.
REQ-032 stall=1 and flush=1 same edge -> bubble; stall=1 alone for 3 edges -> outputs unchanged.
REQ-033 FWD_EN=0, matching mem_rd -> alu_a equals registered rs1_data.
